// File: rtl/lrsc_resv_arbiter_pkg.sv
// lrsc_resv_arbiter_pkg: shared FSM state and memory op encodings for the LR/SC arbiter
package lrsc_resv_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;
endpackage

// File: rtl/lrsc_resv_slot.sv
// lrsc_resv_slot: one hart's LR reservation (valid, word address, optional lifetime countdown)
// Ports: set loads set_adr (wins over clr), clr drops the reservation,
// match = reservation live and equal to chk_adr. LRSC_TIMEOUT_EN adds the countdown.
module lrsc_resv_slot #(
  parameter int PA_BITS = 56,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic               clr,
  input  logic [PA_BITS-3:0] set_adr,
  input  logic [PA_BITS-3:0] chk_adr,
  output logic               match
);
  logic v, valid;
  logic [PA_BITS-3:0] adr;
`ifdef LRSC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // an expired count hides the reservation at once; the flag itself drops on the next edge
  assign valid = v && cnt != '0;
  always_ff @(posedge clk)
    if (reset) begin
      v   <= 1'b0;
      adr <= '0;
      cnt <= '0;
    end else if (set) begin
      v   <= 1'b1;
      adr <= set_adr;
      cnt <= CW'(TIMEOUT);
    end else if (clr || !valid) begin
      v   <= 1'b0;
      cnt <= '0;
    end else
      cnt <= cnt - 1'b1;
`else
  assign valid = v;
  always_ff @(posedge clk)
    if (reset) begin
      v   <= 1'b0;
      adr <= '0;
    end else if (set) begin
      v   <= 1'b1;
      adr <= set_adr;
    end else if (clr)
      v <= 1'b0;
`endif
  assign match = valid && adr == chk_adr;
endmodule

// File: rtl/lrsc_resv_arbiter.sv
// lrsc_resv_arbiter: round-robin memory-port arbiter with per-hart LR/SC reservations
// Ports: Req* per-hart request bundle in, ReqGrant/ReqDone/SCFail one-hot per-hart out,
// Mem* single memory port. Optional LRSC_TIMEOUT_EN gives reservations a TIMEOUT-cycle life.
module lrsc_resv_arbiter
  import lrsc_resv_arbiter_pkg::*;
#(
  parameter int NHARTS  = 2,
  parameter int PA_BITS = 56,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NHARTS-1:0]         ReqValid,
  input  logic [2*NHARTS-1:0]       ReqRW,
  input  logic [NHARTS-1:0]         ReqAtomic,
  input  logic [NHARTS*PA_BITS-1:0] ReqPAdr,
  output logic [NHARTS-1:0]         ReqGrant,
  output logic [NHARTS-1:0]         ReqDone,
  output logic [NHARTS-1:0]         SCFail,
  output logic                      MemValid,
  output logic [1:0]                MemRW,
  output logic [PA_BITS-1:0]        MemPAdr,
  input  logic                      MemReady
);
  localparam int HW = $clog2(NHARTS);
  state_t state, state_n;
  logic [HW-1:0] ptr, hart, gidx;
  logic [1:0] op;
  logic atomic, fail, any, g_sc, idle_gnt, mem_done;
  logic [PA_BITS-1:0] adr;
  logic [PA_BITS-3:0] chk_adr;
  logic [1:0] rw_a [NHARTS];
  logic [PA_BITS-1:0] adr_a [NHARTS];
  logic [NHARTS-1:0] match, set, clr;
  // first requester at or after ptr: scan backwards so the nearest one is written last
  always_comb begin
    gidx = '0;
    for (int i = NHARTS - 1; i >= 0; i--)
      if (ReqValid[(int'(ptr) + i) % NHARTS]) gidx = HW'((int'(ptr) + i) % NHARTS);
  end
  assign any      = |ReqValid;
  assign idle_gnt = state == IDLE && any;
  assign mem_done = state == MEM && MemReady;
  assign g_sc     = ReqAtomic[gidx] && rw_a[gidx] == RW_WRITE;
  // in IDLE the slots judge the incoming SC, otherwise the in-flight store
  assign chk_adr  = state == IDLE ? adr_a[gidx][PA_BITS-1:2] : adr[PA_BITS-1:2];
  always_comb
    state_n = state == IDLE ? (any ? ((g_sc && !match[gidx]) ? RESP : MEM) : IDLE)
            : state == MEM  ? (MemReady ? RESP : MEM)
            : IDLE;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      ptr    <= '0;
      hart   <= '0;
      op     <= '0;
      atomic <= 1'b0;
      adr    <= '0;
      fail   <= 1'b0;
    end else if (idle_gnt) begin
      ptr    <= gidx == HW'(NHARTS - 1) ? '0 : gidx + 1'b1;
      hart   <= gidx;
      op     <= rw_a[gidx];
      atomic <= ReqAtomic[gidx];
      adr    <= adr_a[gidx];
      fail   <= g_sc && !match[gidx];
    end
  for (genvar j = 0; j < NHARTS; j++) begin : g_slot
    assign rw_a[j]  = ReqRW[2*j +: 2];
    assign adr_a[j] = ReqPAdr[PA_BITS*j +: PA_BITS];
    assign set[j]   = mem_done && atomic && op == RW_READ && hart == HW'(j);
    // an SC consumes its own reservation at grant; a completing store kills others' matching ones
    assign clr[j]   = (idle_gnt && g_sc && gidx == HW'(j))
                   || (mem_done && op == RW_WRITE && hart != HW'(j) && match[j]);
    lrsc_resv_slot #(.PA_BITS(PA_BITS), .TIMEOUT(TIMEOUT)) u_slot (
      .clk(clk), .reset(reset), .set(set[j]), .clr(clr[j]),
      .set_adr(adr[PA_BITS-1:2]), .chk_adr(chk_adr), .match(match[j]));
  end
  assign ReqGrant = idle_gnt ? NHARTS'(1) << gidx : '0;
  assign ReqDone  = state == RESP ? NHARTS'(1) << hart : '0;
  assign SCFail   = (state == RESP && fail) ? NHARTS'(1) << hart : '0;
  assign MemValid = state == MEM;
  assign MemRW    = op;
  assign MemPAdr  = adr;
endmodule

// File: tb/tb_lrsc_resv_arbiter.sv
// tb_lrsc_resv_arbiter: scoreboard bench for lrsc_resv_arbiter (2 harts, TIMEOUT=8)
module tb_lrsc_resv_arbiter;
  import lrsc_resv_arbiter_pkg::*;
  localparam int NH = 2, PA = 56;
  logic clk = 0, reset = 1;
  logic [NH-1:0] ReqValid = '0, ReqAtomic = '0;
  logic [2*NH-1:0] ReqRW = '0;
  logic [NH*PA-1:0] ReqPAdr = '0;
  logic [NH-1:0] ReqGrant, ReqDone, SCFail;
  logic MemValid, MemReady = 1;
  logic [1:0] MemRW;
  logic [PA-1:0] MemPAdr;
  int checks = 0, errors = 0, cyc = 0, mptr = 0;
  typedef struct {int h; logic f; int gc; int lat;} exp_t;
  exp_t q[$];
  exp_t me;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  lrsc_resv_arbiter #(.NHARTS(NH), .PA_BITS(PA), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqRW(ReqRW), .ReqAtomic(ReqAtomic),
    .ReqPAdr(ReqPAdr), .ReqGrant(ReqGrant), .ReqDone(ReqDone), .SCFail(SCFail),
    .MemValid(MemValid), .MemRW(MemRW), .MemPAdr(MemPAdr), .MemReady(MemReady));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (ReqGrant != 0) chk("grant_onehot", $onehot(ReqGrant), 1);
      if (ReqDone != 0) begin
        chk("done_onehot", $onehot(ReqDone), 1);
        if (q.size() == 0) chk("unexpected_done", ReqDone, 0);
        else begin
          me = q.pop_front();
          chk("done", ReqDone, 1 << me.h);
          chk("scfail", SCFail, me.f ? 1 << me.h : 0);
          chk("latency", cyc - me.gc, me.lat);
        end
      end
    end
  task automatic wait_grant(input int h, output int g);
    g = -1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      @(negedge clk);
      if (ReqGrant[h]) g = cyc;
    end
    if (g < 0) chk("grant_timeout", ReqGrant, 1 << h);
  endtask
  task automatic req(input int h, input logic [1:0] rw, input logic at, input logic [PA-1:0] a,
                     input logic f, input int stall = 0);
    int g;
    ReqValid[h] = 1;
    ReqRW[2*h +: 2] = rw;
    ReqAtomic[h] = at;
    ReqPAdr[PA*h +: PA] = a;
    wait_grant(h, g);
    if (g < 0) begin
      ReqValid[h] = 0;
      return;
    end
    chk("grant", ReqGrant, 1 << h);
    q.push_back('{h, f, g, f ? 1 : stall + 2});
    mptr = (h + 1) % NH;
    MemReady = stall == 0;
    @(posedge clk);
    #1 ReqValid[h] = 0;
    @(negedge clk);
    if (f) chk("fail_no_mem", MemValid, 0);
    else begin
      chk("memvalid", MemValid, 1);
      chk("memrw", MemRW, rw);
      chk("mempadr", MemPAdr, a);
    end
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk("stall_memvalid", MemValid, 1);
      chk("stall_mempadr", MemPAdr, a);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1 MemReady = 1;
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    #1;
  endtask
  initial begin
    int n, g;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, g;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memvalid", MemValid, 0);
    chk("rst_done", ReqDone, 0);
    chk("rst_scfail", SCFail, 0);
    chk("rst_grant", ReqGrant, 0);
    chk("rst_mempadr", MemPAdr, 0);
    @(posedge clk);
    #1 reset = 0;
    // plain LR/SC, then a repeated SC has nothing left to consume
    req(0, RW_READ, 1, 'h1000, 0);
    req(0, RW_WRITE, 1, 'h1000, 0);
    req(0, RW_WRITE, 1, 'h1000, 1);
    // another hart's store to the same word (byte offset ignored) kills the reservation
    req(0, RW_READ, 1, 'h2000, 0);
    req(1, RW_WRITE, 0, 'h2002, 0);
    req(0, RW_WRITE, 1, 'h2000, 1);
    req(0, RW_READ, 1, 'h2000, 0);
    req(1, RW_WRITE, 0, 'h2008, 0);
    req(0, RW_WRITE, 1, 'h2000, 0);
    // a second LR to the same word leaves the first hart's reservation alone
    req(0, RW_READ, 1, 'h7000, 0);
    req(1, RW_READ, 1, 'h7000, 0);
    req(0, RW_WRITE, 1, 'h7000, 0);
    req(1, RW_WRITE, 1, 'h7000, 1);
    // address mismatch fails and still consumes the reservation
    req(1, RW_READ, 1, 'h9000, 0);
    req(1, RW_WRITE, 1, 'h9004, 1);
    req(1, RW_WRITE, 1, 'h9000, 1);
    // round robin with both harts requesting continuously
    ReqRW = {RW_READ, RW_READ};
    ReqAtomic = '0;
    ReqPAdr = {56'h8100, 56'h8000};
    ReqValid = '1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (ReqGrant != 0) begin
        chk("rr_grant", ReqGrant, 1 << mptr);
        q.push_back('{mptr, 0, cyc, 2});
        mptr = (mptr + 1) % NH;
        n++;
      end
    end
    chk("rr_count", n, 4);
    @(posedge clk);
    #1 ReqValid = '0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("rr_drain", q.size(), 0);
    q.delete();
    #1;
    // backpressure
    req(1, RW_READ, 0, 'h6000, 0, 5);
    // reset during a stalled memory access
    req(0, RW_READ, 1, 'h3000, 0);
    ReqRW[3:2] = RW_READ;
    ReqAtomic[1] = 0;
    ReqPAdr[2*PA-1:PA] = 'h4000;
    ReqValid[1] = 1;
    MemReady = 0;
    wait_grant(1, g);
    @(posedge clk);
    #1 ReqValid[1] = 0;
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rstmem_memvalid_during", MemValid, 1);
    @(posedge clk);
    #1 reset = 0;
    MemReady = 1;
    mptr = 0;
    @(negedge clk);
    chk("rstmem_memvalid_after", MemValid, 0);
    chk("rstmem_no_done", ReqDone, 0);
    @(posedge clk);
    #1;
    req(0, RW_WRITE, 1, 'h3000, 1);
`ifdef LRSC_TIMEOUT_EN
    req(0, RW_READ, 1, 'h5000, 0);
    repeat (4) @(posedge clk);
    #1 req(0, RW_WRITE, 1, 'h5000, 0);
    req(0, RW_READ, 1, 'h5000, 0);
    repeat (8) @(posedge clk);
    #1 req(0, RW_WRITE, 1, 'h5000, 1);
`else
    req(0, RW_READ, 1, 'h5000, 0);
    repeat (100) @(posedge clk);
    #1 req(0, RW_WRITE, 1, 'h5000, 0);
`endif
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
